// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared state type, sizes and character test for the RC4 key search
package rc4_pkg;

  localparam int KEY_W   = 24;
  localparam int MSG_LEN = 32;

  typedef enum logic [2:0] {
    IDLE,
    INIT_RUN,
    KSA_RUN,
    PRGA_RUN,
    CHECK,
    FOUND,
    EXHAUSTED
  } rc4_ks_state_t;

  // A decrypted byte is plausible plaintext if it is a space or a lowercase letter.
  function automatic logic is_valid_char(input logic [7:0] c);
    return (c == 8'h20) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

endpackage

// File: rtl/rc4_output_checker.sv
// rtl/rc4_output_checker.sv - counts and vets decrypted bytes written during one PRGA pass
// Ports: clk, reset (async, high); clear restarts the check; en qualifies d_wren;
//        d_wren/d_data snooped write; pass = all bytes valid and exactly MSG_LEN of them;
//        count = bytes seen, saturating one above MSG_LEN.
module rc4_output_checker
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       d_wren,
  input  logic [7:0] d_data,
  output logic       pass,
  output logic [5:0] count
);

  localparam logic [5:0] CNT_PASS = 6'(MSG_LEN);
  // Holding one above the target is enough to remember "too many bytes".
  localparam logic [5:0] CNT_SAT  = 6'(MSG_LEN + 1);

  logic bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      bad   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      bad   <= 1'b0;
    end else if (en && d_wren) begin
      if (count != CNT_SAT) count <= count + 6'd1;
      if (!is_valid_char(d_data)) bad <= 1'b1;
    end
  end

  assign pass = !bad && (count == CNT_PASS);

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// rtl/rc4_key_search_ctrl.sv - sequences init/KSA/PRGA per candidate key and arbitrates S memory
// Ports: clk, reset (async, high), start pulse; key to KSA; x_start pulses out and x_done
//        pulses in for each phase; per-phase S requests muxed onto s_addr/s_data/s_wren;
//        d_wren/d_data snooped PRGA output; busy, sticky found / exhausted status.
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [KEY_W-1:0] key,
  output logic             init_start,
  output logic             ksa_start,
  output logic             prga_start,
  input  logic             init_done,
  input  logic             ksa_done,
  input  logic             prga_done,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       init_data,
  input  logic             init_wren,
  input  logic [7:0]       ksa_addr,
  input  logic [7:0]       ksa_data,
  input  logic             ksa_wren,
  input  logic [7:0]       prga_addr,
  input  logic [7:0]       prga_data,
  input  logic             prga_wren,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_data,
  output logic             s_wren,
  input  logic             d_wren,
  input  logic [7:0]       d_data,
  output logic             busy,
  output logic             found,
  output logic             exhausted
);

  rc4_ks_state_t state;
  logic          chk_pass;
  logic [5:0]    chk_count;
  logic          key_ok;
  logic          launch;
  logic          retry;

  assign key_ok = chk_pass && (chk_count == 6'(MSG_LEN));
  assign launch = start && ((state == IDLE) || (state == FOUND) || (state == EXHAUSTED));
  assign retry  = (state == CHECK) && !key_ok && (key != KEY_MAX);

  rc4_output_checker u_checker (
    .clk    (clk),
    .reset  (reset),
    .clear  (launch || retry),
    .en     (state == PRGA_RUN),
    .d_wren (d_wren),
    .d_data (d_data),
    .pass   (chk_pass),
    .count  (chk_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      key        <= '0;
      init_start <= 1'b0;
      ksa_start  <= 1'b0;
      prga_start <= 1'b0;
      busy       <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
    end else begin
      init_start <= 1'b0;
      ksa_start  <= 1'b0;
      prga_start <= 1'b0;
      case (state)
        IDLE, FOUND, EXHAUSTED: begin
          if (launch) begin
            state      <= INIT_RUN;
            key        <= '0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            busy       <= 1'b1;
            init_start <= 1'b1;
          end
        end
        INIT_RUN: begin
          if (init_done) begin
            state     <= KSA_RUN;
            ksa_start <= 1'b1;
          end
        end
        KSA_RUN: begin
          if (ksa_done) begin
            state      <= PRGA_RUN;
            prga_start <= 1'b1;
          end
        end
        PRGA_RUN: begin
          if (prga_done) state <= CHECK;
        end
        CHECK: begin
          if (key_ok) begin
            state <= FOUND;
            found <= 1'b1;
            busy  <= 1'b0;
          end else if (key == KEY_MAX) begin
            state     <= EXHAUSTED;
            exhausted <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state      <= INIT_RUN;
            key        <= key + 1'b1;
            init_start <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the phase that owns the current state reaches the S memory.
  always_comb begin
    s_addr = 8'h00;
    s_data = 8'h00;
    s_wren = 1'b0;
    case (state)
      INIT_RUN: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wren = init_wren;
      end
      KSA_RUN: begin
        s_addr = ksa_addr;
        s_data = ksa_data;
        s_wren = ksa_wren;
      end
      PRGA_RUN: begin
        s_addr = prga_addr;
        s_data = prga_data;
        s_wren = prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/rc4_key_search_ctrl.md
# rc4_key_search_ctrl

Top-level sequencer for the RC4 brute-force key search. It runs the S-initialise, key-schedule (KSA) and keystream/decrypt (PRGA) phase controllers in turn for each candidate key. It grants the single-port S working memory to whichever phase is active, and snoops the decrypted-output writes to decide whether the current key yields a valid message. It sits between the top-level start/LED logic and the three phase FSMs.

## Interface
Parameters:
- KEY_W, 24: candidate key width.
- KEY_MAX, 24'h3FFFFF: last key tried; the upper 2 bits are always 0.
- MSG_LEN, 32: decrypted bytes expected per PRGA pass.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a search at key 0.
- key  out  KEY_W  current candidate key, to KSA.
- init_start / ksa_start / prga_start  out  1 each  one-cycle start pulse to each phase.
- init_done / ksa_done / prga_done  in  1 each  one-cycle completion pulse from each phase.
- init_addr, init_data / ksa_addr, ksa_data / prga_addr, prga_data  in  8 each  per-phase S-memory request.
- init_wren / ksa_wren / prga_wren  in  1 each  per-phase S-memory write enable.
- s_addr, s_data  out  8 each  to S memory.
- s_wren  out  1  to S memory.
- d_wren  in  1  snooped PRGA write enable to decrypted RAM.
- d_data  in  8  snooped PRGA write data to decrypted RAM.
- busy  out  1  search in progress.
- found  out  1  sticky; `key` holds the winning key.
- exhausted  out  1  sticky; no key in 0..KEY_MAX passed.

## Operation
- States:
  - IDLE
  - INIT_RUN
  - KSA_RUN
  - PRGA_RUN
  - CHECK
  - FOUND
  - EXHAUSTED
- IDLE/FOUND/EXHAUSTED + start → INIT_RUN on that edge:
  - key←0, found←0, exhausted←0;
  - checker cleared;
  - init_start=1 for that one cycle.
- INIT_RUN + init_done → KSA_RUN, with ksa_start pulsed.
- KSA_RUN + ksa_done → PRGA_RUN, with prga_start pulsed.
- PRGA_RUN + prga_done → CHECK.
- CHECK, one cycle. Pass means bad=0 and byte count = MSG_LEN.
  - Pass → FOUND.
  - Fail with key=KEY_MAX → EXHAUSTED.
  - Otherwise → INIT_RUN: key←key+1, checker cleared, init_start pulsed.
- Checker: every PRGA_RUN cycle with d_wren=1 increments a 6-bit byte count. bad←1 if d_data is neither 8'h20 nor in 8'h61..8'h7A.
  - d_wren outside PRGA_RUN is ignored.
  - A count above MSG_LEN saturates and fails.
- Port grant (combinational from state): in X_RUN, s_addr/s_data/s_wren = that phase's inputs. In all other states s_wren=0, s_addr=0, s_data=0. A non-owner's wren never reaches memory.
- busy=1 in INIT_RUN, KSA_RUN, PRGA_RUN and CHECK.
- start while busy: ignored.
- A done pulse from a non-active phase: ignored. A done pulse in the same cycle as entry to its state is legal and advances.
- found and exhausted are never both 1.

## Timing
- Reset (async) drives:
  - state=IDLE, key=0;
  - all start pulses 0;
  - busy, found, exhausted = 0;
  - s_wren=0 immediately, mid-operation included.
- Start pulses, key, busy, found and exhausted are registered.
- start→init_start: 1 cycle.
- X_done→next start: 1 cycle.
- prga_done→CHECK→next init_start or found/exhausted: 2 edges.
- Per-key overhead beyond phase runtimes: 4 cycles.
- key changes only on the CHECK→INIT_RUN edge; it is stable throughout KSA.
- KEY_MAX wrap never occurs; the search stops at EXHAUSTED.

## Structure
- Package rc4_pkg holds:
  - state enum rc4_ks_state_t;
  - KEY_W, MSG_LEN;
  - function is_valid_char(logic [7:0]).
- The phase FSMs also import MSG_LEN from the package.
- One sub-module: rc4_output_checker. It contains the byte counter and bad flag, with inputs clk, reset, clear, en, d_wren, d_data and outputs pass and count.
- The grant mux stays inline.

## Test plan
- Mock phases with 5-cycle done latency; PRGA mock writes 32 bytes of 8'h61; pulse start → init_start/ksa_start/prga_start each once, found=1 with key=0, busy=0 after CHECK.
- Mock PRGA outputs byte 8'h41 unless key=3 → key steps 0,1,2,3, found=1 with key=3, four init_start pulses.
- KEY_MAX overridden to 5, PRGA always writes 8'h00 → exhausted=1 with key=5, found=0.
- Mock PRGA writes only 31 valid bytes → fail, key increments. d_wren pulses during KSA_RUN do not affect the result.
- All three phases assert wren with distinct addresses every cycle → s_addr matches only the owning phase per state, s_wren=0 in CHECK/IDLE.
- Assert reset during KSA_RUN → same cycle s_wren=0, busy=0, key=0. A later start → clean restart from key 0. start pulsed during PRGA_RUN → no effect.
